// File: rtl/kled_pkg.sv
// Shared encodings for the key/LED controller.
//   mode_e  : LED pattern style (rotate left, rotate right, bounce)
//   speed_e : step-rate multiplier (x1, x2, x4)
//   state_e : control state (paused / running)
//   clog2w  : counter width needed to hold 0..value-1 (never below 1)
package kled_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        SPEED_X1 = 2'd0,
        SPEED_X2 = 2'd1,
        SPEED_X4 = 2'd2
    } speed_e;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Bounce direction flag values
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic int clog2w(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_ROT_L: return MODE_ROT_R;
            MODE_ROT_R: return MODE_BOUNCE;
            default:    return MODE_ROT_L;
        endcase
    endfunction

    function automatic speed_e next_speed(input speed_e s);
        case (s)
            SPEED_X1: return SPEED_X2;
            SPEED_X2: return SPEED_X4;
            default:  return SPEED_X1;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-channel key debouncer.
// The raw key is brought into the clk domain through two flops, then the
// debounced level only follows it after DB_CYCLES consecutive mismatching
// samples. Edge pulses are registered so they line up with the level change.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   key_in    : raw asynchronous key, active-low
//   level     : debounced level, active-low
//   press     : one-cycle pulse on debounced 1->0
//   rel       : one-cycle pulse on debounced 0->1
module key_debounce
    import kled_pkg::*;
#(
    parameter int DB_CYCLES = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_in,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = clog2w(DB_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q,   rel_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        // Any matching sample restarts the stability window
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
                rel_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/key_led_ctrl.sv
// Key-driven LED pattern controller.
// Every key is debounced; keys 0..3 then drive a PAUSE/RUN controller that
// steps a one-hot LED pattern at a selectable rate and style.
//   key[0] toggle run/pause, key[1] next mode, key[2] next speed,
//   key[3] restart pattern at bit 0 (moving left). Higher keys: debounce only.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   key         : raw keys, active-low
//   key_level   : debounced levels, active-low
//   key_press   : one-cycle pulse per debounced press
//   key_release : one-cycle pulse per debounced release
//   led         : one-hot LED pattern
//   running     : 1 while stepping
//   mode, speed : current pattern style and rate multiplier
module key_led_ctrl
    import kled_pkg::*;
#(
    parameter int NKEY        = 4,
    parameter int NLED        = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int STEP_MS     = 1000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NKEY-1:0] key,
    output logic [NKEY-1:0] key_level,
    output logic [NKEY-1:0] key_press,
    output logic [NKEY-1:0] key_release,
    output logic [NLED-1:0] led,
    output logic            running,
    output logic [1:0]      mode,
    output logic [1:0]      speed
);

    localparam int DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int STEP_CYCLES = CLK_HZ / 1000 * STEP_MS;
    localparam int TW          = clog2w(STEP_CYCLES);
    localparam logic [NLED-1:0] LED_INIT = {{(NLED-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < NKEY; i++) begin : g_db
        key_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .rstn   (rstn),
            .key_in (key[i]),
            .level  (key_level[i]),
            .press  (key_press[i]),
            .rel    (key_release[i])
        );
    end

    state_e          state_q, state_d;
    mode_e           mode_q,  mode_d;
    speed_e          speed_q, speed_d;
    logic [TW-1:0]   tick_q,  tick_d;
    logic [NLED-1:0] led_q,   led_d;
    logic            dir_q,   dir_d;
    logic [TW-1:0]   tick_term;
    logic            step;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        speed_d   = speed_q;
        tick_d    = tick_q;
        led_d     = led_q;
        dir_d     = dir_q;
        step      = 1'b0;
        // Faster speeds shorten the period by halving it per level
        tick_term = TW'((STEP_CYCLES >> speed_q) - 1);

        if (state_q == ST_RUN) begin
            if (tick_q == tick_term) begin
                tick_d = '0;
                step   = 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        // The step always uses the mode/direction in force before this
        // cycle's key presses take effect.
        if (step) begin
            case (mode_q)
                MODE_ROT_L: led_d = {led_q[NLED-2:0], led_q[NLED-1]};
                MODE_ROT_R: led_d = {led_q[0], led_q[NLED-1:1]};
                default: begin
                    // Bounce: at an end the direction flips and the same
                    // step already moves back, so the end bit never dwells.
                    if (dir_q == DIR_LEFT) begin
                        if (led_q[NLED-1]) begin
                            dir_d = DIR_RIGHT;
                            led_d = led_q >> 1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_d = DIR_LEFT;
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
            endcase
        end

        if (key_press[0]) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
        if (key_press[1]) begin
            mode_d = next_mode(mode_q);
        end
        if (key_press[2]) begin
            speed_d = next_speed(speed_q);
            tick_d  = '0;
        end
        // Restart wins over a coincident step
        if (key_press[3]) begin
            led_d  = LED_INIT;
            tick_d = '0;
            dir_d  = DIR_LEFT;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_PAUSE;
            mode_q  <= MODE_ROT_L;
            speed_q <= SPEED_X1;
            tick_q  <= '0;
            led_q   <= LED_INIT;
            dir_q   <= DIR_LEFT;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
        end
    end

    assign led     = led_q;
    assign running = (state_q == ST_RUN);
    assign mode    = mode_q;
    assign speed   = speed_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Testbench for key_led_ctrl with small clock/period parameters
// (debounce window 10 cycles, base step period 20 cycles).
module tb_key_led_ctrl;

    localparam int NKEY = 4;
    localparam int NLED = 4;
    localparam int PER  = 20;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NKEY-1:0] key;
    logic [NKEY-1:0] key_level, key_press, key_release;
    logic [NLED-1:0] led;
    logic            running;
    logic [1:0]      mode, speed;

    key_led_ctrl #(
        .NKEY(NKEY), .NLED(NLED), .CLK_HZ(10_000), .DEBOUNCE_MS(1), .STEP_MS(2)
    ) dut (
        .clk(clk), .rstn(rstn), .key(key),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .led(led), .running(running), .mode(mode), .speed(speed)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int press_cnt[NKEY];

    // Reference model: raw key history per key, debounced level, and the
    // LED pattern kept as a bit position.
    logic [15:0] m_h[NKEY];
    logic        m_lvl[NKEY];
    logic        m_press[NKEY];
    logic        m_rel[NKEY];
    bit          m_run, m_dl;
    int          m_mode, m_speed, m_tick, m_pos;

    typedef struct {
        int         k;
        logic       run;
        logic [1:0] md;
        logic [1:0] sp;
        int         led;
    } vec_t;
    vec_t tbl[9];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NKEY; i++) begin
            m_h[i] = '1; m_lvl[i] = 1'b1; m_press[i] = 1'b0; m_rel[i] = 1'b0;
        end
        m_run = 0; m_dl = 1; m_mode = 0; m_speed = 0; m_tick = 0; m_pos = 0;
    endfunction

    function automatic void model_step(input logic [NKEY-1:0] k);
        int per;
        bit term;
        logic p[NKEY];
        for (int i = 0; i < NKEY; i++) p[i] = m_press[i];
        per  = PER >> m_speed;
        term = m_run && (m_tick == per - 1);
        if (m_run) m_tick = term ? 0 : m_tick + 1;
        if (term) begin
            case (m_mode)
                0: m_pos = (m_pos + 1) % NLED;
                1: m_pos = (m_pos + NLED - 1) % NLED;
                default: begin
                    if (m_dl) begin
                        if (m_pos == NLED - 1) begin m_dl = 0; m_pos = m_pos - 1; end
                        else m_pos = m_pos + 1;
                    end else begin
                        if (m_pos == 0) begin m_dl = 1; m_pos = m_pos + 1; end
                        else m_pos = m_pos - 1;
                    end
                end
            endcase
        end
        if (p[0]) m_run = !m_run;
        if (p[1]) m_mode = (m_mode + 1) % 3;
        if (p[2]) begin m_speed = (m_speed + 1) % 3; m_tick = 0; end
        if (p[3]) begin m_pos = 0; m_tick = 0; m_dl = 1; end
        // Level follows once the last 10 synchronized samples (raw samples
        // delayed two edges) all disagree with it.
        for (int i = 0; i < NKEY; i++) begin
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            if (m_h[i][10:1] == {10{~m_lvl[i]}}) begin
                m_lvl[i] = ~m_lvl[i];
                if (m_lvl[i]) m_rel[i] = 1'b1;
                else          m_press[i] = 1'b1;
            end
            m_h[i] = {m_h[i][14:0], k[i]};
        end
    endfunction

    task automatic compare_all();
        logic [NKEY-1:0] el, ep, er;
        for (int i = 0; i < NKEY; i++) begin
            el[i] = m_lvl[i]; ep[i] = m_press[i]; er[i] = m_rel[i];
        end
        chk("key_level", key_level, el);
        chk("key_press", key_press, ep);
        chk("key_release", key_release, er);
        chk("led", led, 32'(1 << m_pos));
        chk("running", running, m_run);
        chk("mode", mode, m_mode);
        chk("speed", speed, m_speed);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rstn) model_reset();
        else       model_step(key);
        @(negedge clk);
        for (int i = 0; i < NKEY; i++) if (key_press[i] === 1'b1) press_cnt[i]++;
        compare_all();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        key  = '1;
        model_reset();
        repeat (3) cyc();
        rstn = 1'b1;
        for (int i = 0; i < NKEY; i++) press_cnt[i] = 0;
    endtask

    task automatic press_key(input int i);
        key[i] = 1'b0;
        repeat (14) cyc();
        key[i] = 1'b1;
        repeat (14) cyc();
    endtask

    task automatic wait_led_change(input int limit, output int n);
        logic [NLED-1:0] prev;
        prev = led;
        n = 0;
        while (led === prev && n < limit) begin
            cyc();
            n++;
        end
        if (led === prev) begin
            n_tests++;
            n_fail++;
            $display("FAIL led_change_timeout: led stuck at %0h after %0d cycles", prev, n);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat;
        logic [NLED-1:0] bseq[7];
        int hold[NKEY];

        tbl[0] = '{0, 1'b1, 2'd0, 2'd0, -1};
        tbl[1] = '{1, 1'b1, 2'd1, 2'd0, -1};
        tbl[2] = '{1, 1'b1, 2'd2, 2'd0, -1};
        tbl[3] = '{1, 1'b1, 2'd0, 2'd0, -1};
        tbl[4] = '{2, 1'b1, 2'd0, 2'd1, -1};
        tbl[5] = '{2, 1'b1, 2'd0, 2'd2, -1};
        tbl[6] = '{2, 1'b1, 2'd0, 2'd0, -1};
        tbl[7] = '{0, 1'b0, 2'd0, 2'd0, -1};
        tbl[8] = '{3, 1'b0, 2'd0, 2'd0, 1};
        bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

        // Reset state
        do_reset();
        chk("rst_key_level", key_level, 4'hF);
        chk("rst_press", key_press, 4'h0);
        chk("rst_led", led, 4'b0001);
        chk("rst_running", running, 1'b0);
        chk("rst_mode", mode, 2'd0);
        chk("rst_speed", speed, 2'd0);

        // Short glitch is ignored
        key[0] = 1'b0;
        repeat (5) cyc();
        key[0] = 1'b1;
        repeat (20) cyc();
        chk("glitch_press_count", press_cnt[0], 0);
        chk("glitch_level", key_level[0], 1'b1);

        // Held key: press latency, single pulse, stepping
        do_reset();
        key[0] = 1'b0;
        lat = 0;
        while (key_press[0] !== 1'b1 && lat < 30) begin
            cyc();
            lat++;
        end
        chk("press_latency", lat, 12);
        cyc();
        chk("press_one_cycle", key_press[0], 1'b0);
        chk("run_after_press", running, 1'b1);
        wait_led_change(40, n);
        chk("rotl_step1", led, 4'b0010);
        wait_led_change(40, n);
        chk("rotl_period", n, 20);
        chk("rotl_step2", led, 4'b0100);
        key[0] = 1'b1;
        repeat (15) cyc();
        chk("release_count_ok", key_level[0], 1'b1);

        // Table of single presses and resulting control outputs
        do_reset();
        for (int v = 0; v < 9; v++) begin
            press_key(tbl[v].k);
            chk("tbl_running", running, tbl[v].run);
            chk("tbl_mode", mode, tbl[v].md);
            chk("tbl_speed", speed, tbl[v].sp);
            if (tbl[v].led >= 0) chk("tbl_led", led, tbl[v].led);
        end

        // Bounce sequence
        do_reset();
        press_key(1);
        press_key(1);
        press_key(0);
        chk("bounce_start", led, 4'b0001);
        for (int s = 0; s < 7; s++) begin
            wait_led_change(25, n);
            chk("bounce_seq", led, bseq[s]);
        end

        // Speed periods
        do_reset();
        press_key(0);
        press_key(2);
        wait_led_change(25, n);
        wait_led_change(25, n);
        chk("period_x2", n, 10);
        press_key(2);
        wait_led_change(25, n);
        wait_led_change(25, n);
        chk("period_x4", n, 5);
        press_key(2);
        wait_led_change(25, n);
        wait_led_change(25, n);
        chk("period_x1", n, 20);

        // Restart coinciding with the tick terminal while led = 0100
        do_reset();
        press_key(0);
        n = 0;
        while (!(m_pos == 2 && m_tick == 7) && n < 200) begin
            cyc();
            n++;
        end
        chk("restart_align_found", (m_pos == 2 && m_tick == 7), 1'b1);
        key[3] = 1'b0;
        repeat (12) cyc();
        chk("restart_before", led, 4'b0100);
        cyc();
        chk("restart_led", led, 4'b0001);
        key[3] = 1'b1;
        wait_led_change(30, n);
        chk("restart_tick_cleared", n, 20);
        chk("restart_next", led, 4'b0010);

        // Asynchronous reset mid-run and mid-debounce
        press_key(1);
        press_key(2);
        key[0] = 1'b0;
        repeat (6) cyc();
        rstn = 1'b0;
        #1;
        chk("arst_key_level", key_level, 4'hF);
        chk("arst_press", key_press, 4'h0);
        chk("arst_release", key_release, 4'h0);
        chk("arst_led", led, 4'b0001);
        chk("arst_running", running, 1'b0);
        chk("arst_mode", mode, 2'd0);
        chk("arst_speed", speed, 2'd0);
        model_reset();
        key = '1;
        repeat (2) cyc();
        rstn = 1'b1;
        for (int i = 0; i < NKEY; i++) press_cnt[i] = 0;
        repeat (20) cyc();
        chk("arst_no_stale_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

        // Randomized key activity against the model
        do_reset();
        for (int i = 0; i < NKEY; i++) hold[i] = $urandom_range(1, 30);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NKEY; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    key[i] = ~key[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9)
                                                          : $urandom_range(10, 40);
                end
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
